toe_conn_ctrl: RTL and testbench
================================

# toe_conn_ctrl

Avalon-MM slave control block for the TCP offload engine that holds `NUM_CONN` independent connection contexts: addresses, ports and initial sequence number. It replaces the single-connection register front end. Host software fills a slot and sets its request bit. A round-robin arbiter dispatches pending slots one at a time to the downstream TX/handshake engine over a valid/ready channel, then records per-slot completion and raises an interrupt.

## Interface
Parameters:
- `NUM_CONN`, 4: number of connection slots, power of two, 1..16.
- `ID_W`, `$clog2(NUM_CONN)` (min 1): slot-index width.
- `ADDR_W`, `4+ID_W`: Avalon word-address width. `address[3:0]` selects the register; `address[ADDR_W-1:4]` selects the slot.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `chipselect`, `read`, `write` in 1: Avalon-MM slave strobes.
- `address` in `ADDR_W`: word address.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt.
- `tx_valid` out 1 / `tx_ready` in 1: dispatch handshake.
- `tx_conn` out `conn_t`: packed context, containing id, ip_src, ip_dst, mac_src[47:0], mac_dst[47:0], port_src[15:0], port_dst[15:0], isn[31:0].
- `done_valid` in 1, `done_id` in `ID_W`, `done_err` in 1: completion pulse from the engine.

## Operation
Per-slot register map (`address[3:0]`):
- 0 CTRL: bit0 REQ (write 1 sets pending; writing 0 has no effect), bit1 IRQ_EN (R/W).
- 1 STATUS (read): bit0 pending, bit1 in_flight, bit2 done, bit3 err.
  - Writing 1 to bit2 clears done and err.
- 2 ISN (32-bit).
- 3 IP_SRC.
- 4 IP_DST.
- 5 MAC_SRC_LO[31:0].
- 6 MAC_DST_LO[31:0].
- 7 PORT_SRC[15:0].
- 8 PORT_DST[15:0].
- 9 MAC_SRC_HI[15:0].
- 10 MAC_DST_HI[15:0].
- 11–15: reads return 0; writes are ignored.

Access rules:
- Writes take effect when `chipselect&write`. Reads take effect when `chipselect&read`. Strobes are qualified by `chipselect`.
- Unused upper bits of narrow registers read 0.
- A slot whose pending or in_flight bit is set is locked: writes to regs 2–10 are ignored. CTRL.IRQ_EN and STATUS remain writable.
- A REQ write to a slot that is already pending, in_flight, or done-with-done=1 is ignored. Done must be cleared before re-requesting.

Dispatch FSM:
- IDLE: if any pending bit is set, select the lowest index at or after `rr_ptr` (wrapping). Latch that slot's context into the `tx_conn` register. Set `tx_valid`, clear the slot's pending bit, set its in_flight bit, go to ISSUE.
- ISSUE: hold `tx_valid` and `tx_conn` stable until `tx_ready`. On handshake, drop `tx_valid`, set `rr_ptr = id+1` mod `NUM_CONN`, go to WAIT.
- WAIT: when `done_valid` arrives with `done_id` equal to the in-flight id, clear in_flight, set done, set err=`done_err`, go to IDLE.
  - A `done_valid` with a non-matching id is ignored.
  - Only one connection is outstanding at a time.

Interrupt:
- `irq = |(done[i] & irq_en[i])`.

Simultaneous events:
- A host W1C of done in the same cycle as a completion on that slot: the completion wins and done stays 1.
- A REQ write in the same cycle the arbiter selects: the new request is seen next cycle.

Reset mid-operation:
- All state clears.
- `tx_valid` drops the cycle after `rst`, even without `tx_ready`.
- A later `done_valid` is ignored (no slot in flight).

## Timing
Reset values:
- `readdata`=0, `irq`=0, `tx_valid`=0, `tx_conn`=0.
- All slot registers are 0.
- `rr_ptr`=0; FSM in IDLE.

Latencies:
- Read latency: 1 cycle. `readdata` is valid the cycle after the read strobe and holds until the next read.
- Write-to-readback: 1 cycle.
- REQ write to `tx_valid`: 2 cycles. The pending bit sets at edge N+1; `tx_valid` rises at edge N+2.
- `done_valid` to the STATUS done bit and `irq`: 1 cycle.
- Back-to-back dispatch: at least 1 IDLE cycle between a done and the next `tx_valid`.

## Structure
- Package `toe_pkg`:
  - `conn_t` packed struct.
  - Register offset localparams `REG_CTRL` … `REG_MAC_DST_HI`.
  - STATUS bit positions.
  - FSM enum `disp_state_t` {IDLE, ISSUE, WAIT}.
- Sub-module `toe_rr_arb`: parametrised round-robin arbiter. Inputs are `req[NUM_CONN]` and `ptr`. Outputs are `gnt_valid` and `gnt_id`. It is purely combinational; `rr_ptr` is registered in the parent.

## Test plan
1. Write slot0 IP_SRC=32'h11111111, IP_DST=32'h22222222, MAC_SRC_LO=32'h00333333, MAC_DST_LO=32'h00444444, PORT_SRC=16'h5555, PORT_DST=16'h6666, then CTRL=1 with `tx_ready`=1.
   -> `tx_valid` for exactly 1 cycle with matching `tx_conn` and id 0.
   -> `done_valid`/id 0 gives STATUS read 32'h4.
2. Hold `tx_ready`=0 for 5 cycles after a request.
   -> `tx_valid` and `tx_conn` stay stable.
   -> STATUS reads 32'h2.
   -> A write of IP_SRC=32'hDEADBEEF to that slot is ignored on readback.
3. Request slots 3, 1 and 2 in the same cycle with `rr_ptr`=0.
   -> Dispatch order is 1, 2, 3.
   -> A re-request of slot 1 after its done is cleared is serviced after 3.
4. Set IRQ_EN on slot 2, complete it with `done_err`=1.
   -> `irq`=1 and STATUS=32'hC.
   -> W1C 32'h4 drops `irq` next cycle; STATUS reads 0.
5. Assert `done_valid` with a wrong id, or while IDLE.
   -> No state change.
   -> A W1C on done coinciding with a completion leaves done=1.
6. Assert `rst` while in ISSUE.
   -> All outputs return to reset values next cycle.
   -> A later `done_valid` is ignored.
   -> Every register reads 0.

Source files
------------

// File: rtl/toe_pkg.sv
// Shared types for the TCP offload connection control block:
// connection context bundle, register offsets, STATUS/CTRL bits, FSM states.
package toe_pkg;

  localparam int CONN_ID_W = 4;

  typedef struct packed {
    logic [CONN_ID_W-1:0] id;
    logic [31:0]          ip_src;
    logic [31:0]          ip_dst;
    logic [47:0]          mac_src;
    logic [47:0]          mac_dst;
    logic [15:0]          port_src;
    logic [15:0]          port_dst;
    logic [31:0]          isn;
  } conn_t;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_ISN        = 4'd2;
  localparam logic [3:0] REG_IP_SRC     = 4'd3;
  localparam logic [3:0] REG_IP_DST     = 4'd4;
  localparam logic [3:0] REG_MAC_SRC_LO = 4'd5;
  localparam logic [3:0] REG_MAC_DST_LO = 4'd6;
  localparam logic [3:0] REG_PORT_SRC   = 4'd7;
  localparam logic [3:0] REG_PORT_DST   = 4'd8;
  localparam logic [3:0] REG_MAC_SRC_HI = 4'd9;
  localparam logic [3:0] REG_MAC_DST_HI = 4'd10;

  localparam int CTRL_REQ    = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_PEND = 0;
  localparam int ST_INFL = 1;
  localparam int ST_DONE = 2;
  localparam int ST_ERR  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } disp_state_t;

endpackage

// File: rtl/toe_rr_arb.sv
// Combinational round-robin arbiter: grants the lowest requesting index
// at or after ptr, wrapping. Ports: req, ptr in; gnt_valid, gnt_id out.
module toe_rr_arb #(
  parameter int NUM_CONN = 4,
  parameter int ID_W     = 2
) (
  input  logic [NUM_CONN-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  output logic                gnt_valid,
  output logic [ID_W-1:0]     gnt_id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = NUM_CONN - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_CONN);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/toe_conn_ctrl.sv
// Avalon-MM multi-connection context store with round-robin dispatch.
// Ports: Avalon slave (chipselect/read/write/address/writedata/readdata),
// irq, tx_valid/tx_ready/tx_conn dispatch, done_valid/done_id/done_err.
module toe_conn_ctrl
  import toe_pkg::*;
#(
  parameter int NUM_CONN = 4,
  parameter int ID_W     = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1,
  parameter int ADDR_W   = 4 + ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              tx_valid,
  input  logic              tx_ready,
  output conn_t             tx_conn,
  input  logic              done_valid,
  input  logic [ID_W-1:0]   done_id,
  input  logic              done_err
);

  conn_t               ctx_q [NUM_CONN];
  logic [NUM_CONN-1:0] pend_q;
  logic [NUM_CONN-1:0] infl_q;
  logic [NUM_CONN-1:0] done_q;
  logic [NUM_CONN-1:0] err_q;
  logic [NUM_CONN-1:0] irqen_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     cur_id_q;
  logic                tx_valid_q;
  conn_t               tx_conn_q;
  logic [31:0]         readdata_q;
  disp_state_t         state_q;
  disp_state_t         state_d;

  logic            wr_en;
  logic            rd_en;
  logic [ID_W-1:0] slot;
  logic [3:0]      reg_sel;
  logic            slot_ok;
  logic            lock;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            latch;
  logic            hs;
  logic            cmpl;
  conn_t           gnt_conn;
  logic [31:0]     rdata_d;
  logic [ID_W-1:0] ptr_nxt;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign slot    = address[ADDR_W-1:4];
  assign reg_sel = address[3:0];
  assign slot_ok = 32'(slot) < NUM_CONN;
  assign lock    = pend_q[slot] | infl_q[slot];

  toe_rr_arb #(
    .NUM_CONN (NUM_CONN),
    .ID_W     (ID_W)
  ) u_arb (
    .req       (pend_q),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    gnt_conn    = ctx_q[gnt_id];
    gnt_conn.id = CONN_ID_W'(gnt_id);
  end

  assign ptr_nxt = (cur_id_q == ID_W'(NUM_CONN - 1))
                 ? '0 : cur_id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    hs      = 1'b0;
    cmpl    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready) begin
          hs      = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done_valid && done_id == cur_id_q) begin
          cmpl    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (slot_ok) begin
      case (reg_sel)
        REG_CTRL:       rdata_d[CTRL_IRQ_EN] = irqen_q[slot];
        REG_STATUS: begin
          rdata_d[ST_PEND] = pend_q[slot];
          rdata_d[ST_INFL] = infl_q[slot];
          rdata_d[ST_DONE] = done_q[slot];
          rdata_d[ST_ERR]  = err_q[slot];
        end
        REG_ISN:        rdata_d = ctx_q[slot].isn;
        REG_IP_SRC:     rdata_d = ctx_q[slot].ip_src;
        REG_IP_DST:     rdata_d = ctx_q[slot].ip_dst;
        REG_MAC_SRC_LO: rdata_d = ctx_q[slot].mac_src[31:0];
        REG_MAC_DST_LO: rdata_d = ctx_q[slot].mac_dst[31:0];
        REG_PORT_SRC:   rdata_d[15:0] = ctx_q[slot].port_src;
        REG_PORT_DST:   rdata_d[15:0] = ctx_q[slot].port_dst;
        REG_MAC_SRC_HI: rdata_d[15:0] = ctx_q[slot].mac_src[47:32];
        REG_MAC_DST_HI: rdata_d[15:0] = ctx_q[slot].mac_dst[47:32];
        default:        rdata_d = '0;
      endcase
    end
  end

  // Host accesses are applied before FSM updates so that a completion
  // overrides a same-cycle W1C of done on the finishing slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONN; i++) ctx_q[i] <= '0;
      pend_q     <= '0;
      infl_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      irqen_q    <= '0;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_conn_q  <= '0;
      readdata_q <= '0;
      state_q    <= IDLE;
    end else begin
      state_q <= state_d;
      if (wr_en && slot_ok) begin
        case (reg_sel)
          REG_CTRL: begin
            irqen_q[slot] <= writedata[CTRL_IRQ_EN];
            if (writedata[CTRL_REQ] && !lock && !done_q[slot])
              pend_q[slot] <= 1'b1;
          end
          REG_STATUS: begin
            if (writedata[ST_DONE]) begin
              done_q[slot] <= 1'b0;
              err_q[slot]  <= 1'b0;
            end
          end
          REG_ISN:
            if (!lock) ctx_q[slot].isn <= writedata;
          REG_IP_SRC:
            if (!lock) ctx_q[slot].ip_src <= writedata;
          REG_IP_DST:
            if (!lock) ctx_q[slot].ip_dst <= writedata;
          REG_MAC_SRC_LO:
            if (!lock) ctx_q[slot].mac_src[31:0] <= writedata;
          REG_MAC_DST_LO:
            if (!lock) ctx_q[slot].mac_dst[31:0] <= writedata;
          REG_PORT_SRC:
            if (!lock) ctx_q[slot].port_src <= writedata[15:0];
          REG_PORT_DST:
            if (!lock) ctx_q[slot].port_dst <= writedata[15:0];
          REG_MAC_SRC_HI:
            if (!lock) ctx_q[slot].mac_src[47:32] <= writedata[15:0];
          REG_MAC_DST_HI:
            if (!lock) ctx_q[slot].mac_dst[47:32] <= writedata[15:0];
          default: ;
        endcase
      end
      if (latch) begin
        tx_valid_q     <= 1'b1;
        tx_conn_q      <= gnt_conn;
        cur_id_q       <= gnt_id;
        pend_q[gnt_id] <= 1'b0;
        infl_q[gnt_id] <= 1'b1;
      end
      if (hs) begin
        tx_valid_q <= 1'b0;
        rr_ptr_q   <= ptr_nxt;
      end
      if (cmpl) begin
        infl_q[cur_id_q] <= 1'b0;
        done_q[cur_id_q] <= 1'b1;
        err_q[cur_id_q]  <= done_err;
      end
      if (rd_en) readdata_q <= rdata_d;
    end
  end

  assign readdata = readdata_q;
  assign tx_valid = tx_valid_q;
  assign tx_conn  = tx_conn_q;
  assign irq      = |(done_q & irqen_q);

endmodule

// File: tb/tb_toe_conn_ctrl.sv
// Directed bench for toe_conn_ctrl: register access, dispatch order,
// completion, interrupt and reset behaviour with hand-computed values.
module tb_toe_conn_ctrl;
  import toe_pkg::*;

  localparam int NC = 4;
  localparam int IW = 2;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  conn_t         tx_conn;
  logic          done_valid = 1'b0;
  logic [IW-1:0] done_id = '0;
  logic          done_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rv;
  conn_t exp_c;

  always #5 clk = ~clk;

  toe_conn_ctrl #(.NUM_CONN(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_conn    (tx_conn),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkc(input string tag, input conn_t exp);
    vectors++;
    assert (tx_conn === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, tx_conn, exp);
    end
  endtask

  task automatic wr(input int s, input logic [3:0] r,
                    input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = AW'(s * 16 + int'(r));
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input int s, input logic [3:0] r,
                    output logic [31:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = AW'(s * 16 + int'(r));
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  task automatic complete(input int id, input logic err);
    done_valid = 1'b1;
    done_id    = IW'(id);
    done_err   = err;
    tick();
    done_valid = 1'b0;
    done_err   = 1'b0;
  endtask

  task automatic dispatch(input int id);
    int n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("disp_valid", 32'(tx_valid), 32'd1);
    check("disp_id", 32'(tx_conn.id), 32'(id));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_txv", 32'(tx_valid), 32'h0);
    exp_c = '0;
    checkc("rst_conn", exp_c);

    // 1: single dispatch with ready high
    tx_ready = 1'b1;
    wr(0, REG_IP_SRC, 32'h11111111);
    wr(0, REG_IP_DST, 32'h22222222);
    wr(0, REG_MAC_SRC_LO, 32'h00333333);
    wr(0, REG_MAC_DST_LO, 32'h00444444);
    wr(0, REG_PORT_SRC, 32'h00005555);
    wr(0, REG_PORT_DST, 32'h00006666);
    rd(0, REG_IP_DST, rv);
    check("t1_rb_ipdst", rv, 32'h22222222);
    wr(0, REG_CTRL, 32'h1);
    check("t1_lat1", 32'(tx_valid), 32'h0);
    tick();
    check("t1_lat2", 32'(tx_valid), 32'h1);
    exp_c          = '0;
    exp_c.id       = 4'd0;
    exp_c.ip_src   = 32'h11111111;
    exp_c.ip_dst   = 32'h22222222;
    exp_c.mac_src  = 48'h000000333333;
    exp_c.mac_dst  = 48'h000000444444;
    exp_c.port_src = 16'h5555;
    exp_c.port_dst = 16'h6666;
    checkc("t1_conn", exp_c);
    tick();
    check("t1_pulse", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    complete(0, 1'b0);
    rd(0, REG_STATUS, rv);
    check("t1_status", rv, 32'h4);
    check("t1_irq", 32'(irq), 32'h0);
    wr(0, REG_STATUS, 32'h4);

    // 2: backpressure holds tx_valid/tx_conn, slot locked
    wr(1, REG_ISN, 32'h12345678);
    wr(1, REG_IP_SRC, 32'hA0A0A0A0);
    wr(1, REG_CTRL, 32'h1);
    tick();
    exp_c        = '0;
    exp_c.id     = 4'd1;
    exp_c.isn    = 32'h12345678;
    exp_c.ip_src = 32'hA0A0A0A0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_v", 32'(tx_valid), 32'h1);
      checkc("t2_hold_c", exp_c);
      tick();
    end
    check("t2_hold_v5", 32'(tx_valid), 32'h1);
    rd(1, REG_STATUS, rv);
    check("t2_status", rv, 32'h2);
    wr(1, REG_IP_SRC, 32'hDEADBEEF);
    rd(1, REG_IP_SRC, rv);
    check("t2_locked", rv, 32'hA0A0A0A0);
    checkc("t2_hold_c2", exp_c);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("t2_hs", 32'(tx_valid), 32'h0);
    complete(1, 1'b0);
    wr(1, REG_STATUS, 32'h4);

    // 3: round-robin order 1,2,3 then re-requested 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, REG_CTRL, 32'h1);
    wr(3, REG_CTRL, 32'h1);
    wr(1, REG_CTRL, 32'h1);
    wr(2, REG_CTRL, 32'h1);
    dispatch(0);
    complete(0, 1'b0);
    dispatch(1);
    complete(1, 1'b0);
    wr(1, REG_STATUS, 32'h4);
    wr(1, REG_CTRL, 32'h1);
    rd(1, REG_STATUS, rv);
    check("t3_rereq", rv, 32'h1);
    dispatch(2);
    complete(2, 1'b0);
    dispatch(3);
    complete(3, 1'b0);
    dispatch(1);
    complete(1, 1'b0);

    // 4: interrupt with error
    wr(2, REG_STATUS, 32'h4);
    wr(2, REG_CTRL, 32'h3);
    dispatch(2);
    check("t4_irq_pre", 32'(irq), 32'h0);
    complete(2, 1'b1);
    check("t4_irq", 32'(irq), 32'h1);
    rd(2, REG_STATUS, rv);
    check("t4_status", rv, 32'hC);
    rd(2, REG_CTRL, rv);
    check("t4_irqen", rv, 32'h2);
    wr(2, REG_STATUS, 32'h4);
    check("t4_irq_clr", 32'(irq), 32'h0);
    rd(2, REG_STATUS, rv);
    check("t4_status_clr", rv, 32'h0);

    // 5: stray completions and W1C/completion collision
    complete(3, 1'b1);
    rd(3, REG_STATUS, rv);
    check("t5_idle_done", rv, 32'h4);
    wr(0, REG_STATUS, 32'h4);
    wr(0, REG_CTRL, 32'h1);
    dispatch(0);
    complete(1, 1'b1);
    rd(0, REG_STATUS, rv);
    check("t5_wrong_id", rv, 32'h2);
    rd(1, REG_STATUS, rv);
    check("t5_other", rv, 32'h4);
    done_valid = 1'b1;
    done_id    = 2'd0;
    wr(0, REG_STATUS, 32'h4);
    done_valid = 1'b0;
    rd(0, REG_STATUS, rv);
    check("t5_collide", rv, 32'h4);

    // 6: reset while in ISSUE
    wr(1, REG_STATUS, 32'h4);
    wr(1, REG_CTRL, 32'h3);
    tick();
    check("t6_issue", 32'(tx_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_txv", 32'(tx_valid), 32'h0);
    exp_c = '0;
    checkc("t6_conn", exp_c);
    check("t6_irq", 32'(irq), 32'h0);
    check("t6_rdata", readdata, 32'h0);
    complete(1, 1'b1);
    check("t6_irq2", 32'(irq), 32'h0);
    for (int s = 0; s < NC; s++) begin
      for (int r = 0; r < 16; r++) begin
        rd(s, 4'(r), rv);
        check("t6_regs", rv, 32'h0);
      end
    end
    check("t6_txv2", 32'(tx_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
